// File: rtl/router_pkg.sv
// Flit layout, slot indices and small field helpers shared by the router local port.
package router_pkg;

    localparam int FLIT_W    = 32;
    localparam int NUM_SLOTS = 4;
    localparam int VALID_BIT = 31;
    localparam int AGE_MSB   = 30;
    localparam int AGE_LSB   = 23;
    localparam int DEST_MSB  = 11;
    localparam int DEST_LSB  = 8;
    localparam int ROUTE_MSB = 6;
    localparam int ROUTE_LSB = 4;

    localparam int SLOT_N = 0;
    localparam int SLOT_E = 1;
    localparam int SLOT_S = 2;
    localparam int SLOT_W = 3;

    localparam logic [7:0] AGE_MAX = 8'd255;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam flit_t FLIT_NULL = {FLIT_W{1'b0}};

    function automatic logic flit_valid(input flit_t f);
        return f[VALID_BIT];
    endfunction

    function automatic logic [7:0] flit_age(input flit_t f);
        return f[AGE_MSB:AGE_LSB];
    endfunction

    function automatic logic [3:0] flit_dest(input flit_t f);
        return f[DEST_MSB:DEST_LSB];
    endfunction

    // Age a surviving flit by one, saturating; invalid flits are returned untouched.
    function automatic flit_t flit_aged(input flit_t f);
        flit_t r;
        r = f;
        if (f[VALID_BIT] && (f[AGE_MSB:AGE_LSB] != AGE_MAX)) begin
            r[AGE_MSB:AGE_LSB] = f[AGE_MSB:AGE_LSB] + 8'd1;
        end else begin
            r[AGE_MSB:AGE_LSB] = f[AGE_MSB:AGE_LSB];
        end
        return r;
    endfunction

    function automatic flit_t flit_injected(input flit_t f);
        flit_t r;
        r = f;
        r[VALID_BIT]       = 1'b1;
        r[AGE_MSB:AGE_LSB] = 8'd0;
        return r;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with registered count; head reads as all-zero while empty.
module flit_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  flit_t push_data_i,
    input  logic  pop_i,
    output flit_t head_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int PW = $clog2(DEPTH);

    flit_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == (PW+1)'(DEPTH));
    assign empty_o   = (count_q == (PW+1)'(0));
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = empty_o ? FLIT_NULL : mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            wr_ptr_q <= do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_q <= do_pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/router_local_port.sv
// Local endpoint of the deflection router: ejects one local flit, injects one core
// flit into a free slot, ages the survivors and registers the four slots.
module router_local_port
    import router_pkg::*;
#(
    parameter logic [3:0] NODE_ID   = 4'd0,
    parameter int         INJ_DEPTH = 4,
    parameter int         EJ_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_n,
    input  logic [31:0] in_e,
    input  logic [31:0] in_s,
    input  logic [31:0] in_w,
    output logic [31:0] out_n,
    output logic [31:0] out_e,
    output logic [31:0] out_s,
    output logic [31:0] out_w,
    input  logic        inj_valid,
    input  logic [31:0] inj_flit,
    output logic        inj_ready,
    output logic        ej_valid,
    output logic [31:0] ej_flit,
    input  logic        ej_ready,
    output logic [15:0] starve_cnt
);

    flit_t                slot_in_s [NUM_SLOTS];
    flit_t                post_ej_s [NUM_SLOTS];
    flit_t                out_d     [NUM_SLOTS];
    flit_t                out_q     [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] ej_take_s;
    logic [NUM_SLOTS-1:0] inj_take_s;
    logic                 cand_found_s;
    logic [1:0]           ej_idx_s;
    logic [7:0]           best_age_s;
    logic                 eject_s;
    logic                 free_found_s;
    logic [1:0]           inj_idx_s;
    logic                 inject_s;
    logic [15:0]          starve_d;
    logic [15:0]          starve_q;
    flit_t                inj_head_s;
    flit_t                ej_head_s;
    logic                 inj_full_s;
    logic                 inj_empty_s;
    logic                 ej_full_s;
    logic                 ej_empty_s;

    // Eject arbitration: oldest local flit wins, strict '>' keeps ties on the lowest slot.
    always_comb begin
        slot_in_s[SLOT_N] = in_n;
        slot_in_s[SLOT_E] = in_e;
        slot_in_s[SLOT_S] = in_s;
        slot_in_s[SLOT_W] = in_w;
        ej_take_s    = {NUM_SLOTS{1'b0}};
        cand_found_s = 1'b0;
        ej_idx_s     = 2'd0;
        best_age_s   = 8'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ej_take_s[i] = flit_valid(slot_in_s[i]) && (flit_dest(slot_in_s[i]) == NODE_ID) &&
                           (!cand_found_s || (flit_age(slot_in_s[i]) > best_age_s));
            cand_found_s = cand_found_s | ej_take_s[i];
            ej_idx_s     = ej_take_s[i] ? 2'(i) : ej_idx_s;
            best_age_s   = ej_take_s[i] ? flit_age(slot_in_s[i]) : best_age_s;
        end
    end

    // Clear the ejected slot, place the injection head in the lowest hole, age the rest.
    always_comb begin
        eject_s      = cand_found_s && !ej_full_s;
        inj_take_s   = {NUM_SLOTS{1'b0}};
        free_found_s = 1'b0;
        inj_idx_s    = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            post_ej_s[i]  = ((eject_s && (ej_idx_s == 2'(i))) || !flit_valid(slot_in_s[i])) ?
                            FLIT_NULL : slot_in_s[i];
            inj_take_s[i] = !flit_valid(post_ej_s[i]) && !free_found_s;
            free_found_s  = free_found_s | inj_take_s[i];
            inj_idx_s     = inj_take_s[i] ? 2'(i) : inj_idx_s;
        end
        inject_s = !inj_empty_s && free_found_s;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            out_d[i] = (inject_s && (inj_idx_s == 2'(i))) ? flit_injected(inj_head_s) :
                       flit_aged(post_ej_s[i]);
        end
        starve_d = (inj_empty_s || inject_s) ? 16'd0 :
                   ((starve_q == 16'hFFFF) ? starve_q : starve_q + 16'd1);
    end

    // Slot output and starvation counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                out_q[i] <= FLIT_NULL;
            end
            starve_q <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                out_q[i] <= out_d[i];
            end
            starve_q <= starve_d;
        end
    end

    flit_fifo #(.DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inj_valid && !inj_full_s),
        .push_data_i (inj_flit),
        .pop_i       (inject_s),
        .head_o      (inj_head_s),
        .full_o      (inj_full_s),
        .empty_o     (inj_empty_s)
    );

    flit_fifo #(.DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (eject_s),
        .push_data_i (slot_in_s[ej_idx_s]),
        .pop_i       (!ej_empty_s && ej_ready),
        .head_o      (ej_head_s),
        .full_o      (ej_full_s),
        .empty_o     (ej_empty_s)
    );

    assign out_n      = out_q[SLOT_N];
    assign out_e      = out_q[SLOT_E];
    assign out_s      = out_q[SLOT_S];
    assign out_w      = out_q[SLOT_W];
    assign inj_ready  = !inj_full_s;
    assign ej_valid   = !ej_empty_s;
    assign ej_flit    = ej_head_s;
    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_router_local_port.sv
// Bench for router_local_port: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_router_local_port;

    localparam logic [3:0] NODE = 4'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_n, in_e, in_s, in_w;
    logic [31:0] out_n, out_e, out_s, out_w;
    logic        inj_valid;
    logic [31:0] inj_flit;
    logic        inj_ready;
    logic        ej_valid;
    logic [31:0] ej_flit;
    logic        ej_ready;
    logic [15:0] starve_cnt;

    always #5 clk = ~clk;

    router_local_port #(.NODE_ID(NODE), .INJ_DEPTH(4), .EJ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_n(in_n), .in_e(in_e), .in_s(in_s), .in_w(in_w),
        .out_n(out_n), .out_e(out_e), .out_s(out_s), .out_w(out_w),
        .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_flit(ej_flit), .ej_ready(ej_ready),
        .starve_cnt(starve_cnt)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_out [4];
    logic [31:0] inj_q [$];
    logic [31:0] ej_q [$];
    int          exp_starve = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rnd_flit();
        logic [31:0] f;
        f = $urandom;
        f[31] = ($urandom_range(0, 3) != 0);
        f[30:23] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        f[11:8] = ($urandom_range(0, 1) == 0) ? NODE : 4'($urandom_range(0, 15));
        return f;
    endfunction

    // Reference: one router cycle computed from the current inputs and queued state.
    task automatic model_step();
        logic [31:0] s [4];
        logic [31:0] ejf;
        int win, ip, a;
        bit ej_full, inj_full, had_inj, ejected, injected;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) exp_out[i] = 32'd0;
            inj_q.delete();
            ej_q.delete();
            exp_starve = 0;
            return;
        end
        s = '{in_n, in_e, in_s, in_w};
        ej_full  = (ej_q.size() >= 2);
        inj_full = (inj_q.size() >= 4);
        had_inj  = (inj_q.size() > 0);
        win = -1;
        for (int i = 0; i < 4; i++)
            if (s[i][31] && s[i][11:8] == NODE && (win < 0 || s[i][30:23] > s[win][30:23])) win = i;
        ejected = 1'b0;
        ejf = 32'd0;
        if (win >= 0 && !ej_full) begin
            ejf = s[win];
            ejected = 1'b1;
            s[win] = 32'd0;
        end
        for (int i = 0; i < 4; i++) if (!s[i][31]) s[i] = 32'd0;
        ip = -1;
        if (had_inj) for (int i = 0; i < 4; i++) if (ip < 0 && !s[i][31]) ip = i;
        for (int i = 0; i < 4; i++) begin
            if (s[i][31]) begin
                a = int'(s[i][30:23]) + 1;
                if (a > 255) a = 255;
                s[i][30:23] = a[7:0];
            end
        end
        injected = 1'b0;
        if (ip >= 0) begin
            s[ip] = inj_q.pop_front();
            s[ip][31] = 1'b1;
            s[ip][30:23] = 8'd0;
            injected = 1'b1;
        end
        exp_starve = (!had_inj || injected) ? 0 : ((exp_starve >= 65535) ? 65535 : exp_starve + 1);
        if (ej_q.size() > 0 && ej_ready) void'(ej_q.pop_front());
        if (ejected) ej_q.push_back(ejf);
        if (inj_valid && !inj_full) inj_q.push_back(inj_flit);
        for (int i = 0; i < 4; i++) exp_out[i] = s[i];
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_n", out_n, exp_out[0]);
            chk("out_e", out_e, exp_out[1]);
            chk("out_s", out_s, exp_out[2]);
            chk("out_w", out_w, exp_out[3]);
            chk("inj_ready", 32'(inj_ready), (inj_q.size() < 4) ? 32'd1 : 32'd0);
            chk("ej_valid", 32'(ej_valid), (ej_q.size() > 0) ? 32'd1 : 32'd0);
            chk("starve_cnt", 32'(starve_cnt), 32'(exp_starve));
            if (ej_q.size() > 0) chk("ej_flit", ej_flit, ej_q[0]);
        end
    end

    initial begin
        rst_n = 1'b0; inj_valid = 1'b0; inj_flit = 32'd0; ej_ready = 1'b1;
        in_n = $urandom; in_e = $urandom; in_s = $urandom; in_w = $urandom;
        cyc();
        chk_en = 1'b1;
        repeat (2) begin
            in_n = $urandom; in_e = $urandom; in_s = $urandom; in_w = $urandom;
            cyc();
        end
        chk("rst_out_n", out_n, 32'h0);
        chk("rst_out_w", out_w, 32'h0);
        chk("rst_inj_ready", 32'(inj_ready), 32'd1);
        chk("rst_ej_valid", 32'(ej_valid), 32'd0);
        chk("rst_ej_flit", ej_flit, 32'h0);
        chk("rst_starve", 32'(starve_cnt), 32'd0);

        rst_n = 1'b1;
        in_n = 32'h8500_0200; in_e = 32'd0; in_s = 32'd0; in_w = 32'd0;
        cyc();
        chk("release_out_n", out_n, 32'h8580_0200);

        // Oldest local flit ejected, the other deflected with age+1
        in_n = 32'd0; in_e = 32'h8180_0500; in_s = 32'h8480_0500;
        cyc();
        chk("eject_out_e", out_e, 32'h8200_0500);
        chk("eject_out_s", out_s, 32'h0);
        chk("eject_ej_valid", 32'(ej_valid), 32'd1);
        chk("eject_ej_flit", ej_flit, 32'h8480_0500);
        in_e = 32'd0; in_s = 32'd0;
        cyc();

        // Eject W, then inject the queued core flit into W
        inj_valid = 1'b1; inj_flit = 32'h0000_0ABC;
        cyc();
        inj_valid = 1'b0;
        in_n = 32'h8080_0100; in_e = 32'h8080_0200; in_s = 32'h8080_0300; in_w = 32'h8080_0500;
        cyc();
        chk("inj_out_w", out_w, 32'h8000_0ABC);
        chk("inj_out_n", out_n, 32'h8100_0100);
        chk("inj_ej_flit", ej_flit, 32'h8080_0500);
        in_n = 32'd0; in_e = 32'd0; in_s = 32'd0; in_w = 32'd0;
        cyc();
        chk("inj_fifo_drained", out_w, 32'h0);

        // Starvation for 10 cycles, then a hole on E
        in_n = 32'h8080_0100; in_e = 32'h8080_0200; in_s = 32'h8080_0300; in_w = 32'h8080_0400;
        inj_valid = 1'b1; inj_flit = 32'h0000_0DEF;
        cyc();
        inj_valid = 1'b0;
        repeat (10) cyc();
        chk("starve_10", 32'(starve_cnt), 32'd10);
        in_e = 32'd0;
        cyc();
        chk("starve_inj_out_e", out_e, 32'h8000_0DEF);
        chk("starve_clear", 32'(starve_cnt), 32'd0);
        in_n = 32'd0; in_s = 32'd0; in_w = 32'd0;

        // Ejection backpressure
        ej_ready = 1'b0;
        in_n = 32'h8100_0500;
        cyc();
        chk("bp_first", out_n, 32'h0);
        cyc();
        chk("bp_second", out_n, 32'h0);
        cyc();
        chk("bp_third_deflect", out_n, 32'h8180_0500);
        chk("bp_ej_valid", 32'(ej_valid), 32'd1);
        chk("bp_ej_head", ej_flit, 32'h8100_0500);
        in_n = 32'd0; ej_ready = 1'b1;
        repeat (3) cyc();

        // Age saturation
        in_n = 32'hFF80_0300;
        cyc();
        chk("age_sat", out_n, 32'hFF80_0300);

        // Injection FIFO wrap and order
        in_n = 32'h8080_0100; in_e = 32'h8080_0200; in_s = 32'h8080_0300; in_w = 32'h8080_0400;
        for (int k = 0; k < 4; k++) begin
            inj_valid = 1'b1; inj_flit = 32'h0000_1000 + 32'(k);
            cyc();
        end
        inj_valid = 1'b0;
        chk("wrap_full4", 32'(inj_ready), 32'd0);
        in_n = 32'd0;
        cyc();
        chk("wrap_pop0", out_n, 32'h8000_1000);
        cyc();
        chk("wrap_pop1", out_n, 32'h8000_1001);
        in_n = 32'h8080_0100;
        for (int k = 4; k < 6; k++) begin
            inj_valid = 1'b1; inj_flit = 32'h0000_1000 + 32'(k);
            cyc();
        end
        inj_valid = 1'b0;
        chk("wrap_full6", 32'(inj_ready), 32'd0);
        in_n = 32'd0; in_e = 32'd0; in_s = 32'd0; in_w = 32'd0;
        for (int k = 2; k < 6; k++) begin
            cyc();
            chk("wrap_order", out_n, 32'h8000_1000 + 32'(k));
        end

        // Randomized traffic with occasional mid-run reset
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_n      = rnd_flit();
            in_e      = rnd_flit();
            in_s      = rnd_flit();
            in_w      = rnd_flit();
            inj_valid = ($urandom_range(0, 1) != 0);
            inj_flit  = $urandom;
            ej_ready  = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
